// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: routing mode
// encoding, drop counter limits and the select-width helper.
package demux_pkg;

  // Routing mode, sampled once per accepted beat
  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  localparam int          DROP_CNT_W   = 8;
  localparam logic [7:0]  DROP_CNT_MAX = 8'hFF;

  // Width of a channel index; a single channel bit is kept even for tiny N
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      sel_width = 1;
    end else begin
      sel_width = w;
    end
  endfunction

endpackage

// File: rtl/rr_ptr_gen.sv
// Round-robin channel pointer: counts 0..N-1 and wraps, stepping only
// when the parent accepts a round-robin beat.
module rr_ptr_gen
  import demux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [SEL_W-1:0] ptr
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] ONE      = SEL_W'(1);

  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_nxt_s;

  // Next pointer: hold unless advancing, wrap from the last channel to 0
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (!advance) begin
      ptr_nxt_s = ptr_r;
    end else if (ptr_r == LAST_IDX) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_r + ONE;
    end
  end

  // Pointer register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N valid/ready stream demultiplexer with a single output holding
// register. Beats are routed by in_sel (addressed mode) or by a rotating
// pointer (round-robin mode); addressed beats to a non-existent channel are
// swallowed and counted.
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_count
);

  // One extra bit so that "in_sel >= N" is representable when N = 2**SEL_W
  localparam logic [SEL_W:0] N_LIMIT = (SEL_W + 1)'(N);

  logic                  full_r;
  logic [SEL_W-1:0]      dest_r;
  logic [WIDTH-1:0]      data_r;
  logic [N-1:0]          out_valid_r;
  logic                  drop_pulse_r;
  logic [DROP_CNT_W-1:0] drop_count_r;

  logic                  full_s;
  logic [SEL_W-1:0]      dest_s;
  logic [WIDTH-1:0]      data_s;
  logic [N-1:0]          out_valid_s;
  logic [DROP_CNT_W-1:0] drop_count_s;
  logic                  drain_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  drop_s;
  logic                  load_s;
  logic                  rr_advance_s;
  logic [SEL_W-1:0]      target_s;
  logic [SEL_W-1:0]      rr_ptr_s;

  // Decode a channel index into the per-channel valid vector
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_ptr_gen #(
    .N (N)
  ) u_rr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (rr_advance_s),
    .ptr     (rr_ptr_s)
  );

  // Handshake decode: only the destination's ready can free the register
  always_comb begin
    drain_s      = full_r && out_ready[dest_r];
    in_ready_s   = !full_r || drain_s;
    accept_s     = in_valid && in_ready_s;
    drop_s       = 1'b0;
    rr_advance_s = 1'b0;
    target_s     = in_sel;
    if (mode == MODE_RR) begin
      target_s     = rr_ptr_s;
      rr_advance_s = accept_s;
    end else begin
      target_s = in_sel;
      drop_s   = accept_s && ({1'b0, in_sel} >= N_LIMIT);
    end
    load_s = accept_s && !drop_s;
  end

  // Next state of the holding register; a drain and a load in the same
  // cycle keep the register full with the new beat
  always_comb begin
    full_s       = full_r;
    dest_s       = dest_r;
    data_s       = data_r;
    drop_count_s = drop_count_r;
    if (load_s) begin
      full_s = 1'b1;
      dest_s = target_s;
      data_s = in_data;
    end else if (drain_s) begin
      full_s = 1'b0;
    end else begin
      full_s = full_r;
    end
    if (drop_s && (drop_count_r != DROP_CNT_MAX)) begin
      drop_count_s = drop_count_r + 8'd1;
    end else begin
      drop_count_s = drop_count_r;
    end
    if (full_s) begin
      out_valid_s = onehot(dest_s);
    end else begin
      out_valid_s = '0;
    end
  end

  // Holding register, output valid vector and drop statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r       <= 1'b0;
      dest_r       <= '0;
      data_r       <= '0;
      out_valid_r  <= '0;
      drop_pulse_r <= 1'b0;
      drop_count_r <= '0;
    end else begin
      full_r       <= full_s;
      dest_r       <= dest_s;
      data_r       <= data_s;
      out_valid_r  <= out_valid_s;
      drop_pulse_r <= drop_s;
      drop_count_r <= drop_count_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_data   = data_r;
  assign out_valid  = out_valid_r;
  assign drop_pulse = drop_pulse_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: one N=4 and one N=3 instance driven side by
// side, checked every cycle against a transaction-level model of the block.
module tb_demux_1xn_stream;

  logic       clk;
  logic       rst_n;
  logic       mode_v [2];
  logic [7:0] din_v  [2];
  logic [1:0] sel_v  [2];
  logic       vld_v  [2];
  logic [3:0] ordy_v [2];

  logic       irdy4, irdy3;
  logic [7:0] dout4, dout3;
  logic [3:0] ov4;
  logic [2:0] ov3;
  logic       dp4, dp3;
  logic [7:0] dc4, dc3;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: held beat (valid, channel, payload), rr position, drops
  int nch     [2] = '{4, 3};
  int m_full  [2];
  int m_chan  [2];
  int m_data  [2];
  int m_rr    [2];
  int m_drops [2];
  int m_pulse [2];

  demux_1xn_stream #(.WIDTH(8), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode_v[0]), .in_data(din_v[0]),
    .in_sel(sel_v[0]), .in_valid(vld_v[0]), .in_ready(irdy4),
    .out_data(dout4), .out_valid(ov4), .out_ready(ordy_v[0]),
    .drop_pulse(dp4), .drop_count(dc4)
  );

  demux_1xn_stream #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode_v[1]), .in_data(din_v[1]),
    .in_sel(sel_v[1]), .in_valid(vld_v[1]), .in_ready(irdy3),
    .out_data(dout3), .out_valid(ov3), .out_ready(ordy_v[1][2:0]),
    .drop_pulse(dp3), .drop_count(dc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int i, output logic irdy, output logic [7:0] dout,
                        output logic [3:0] ov, output logic dp, output logic [7:0] dc);
    if (i == 0) begin
      irdy = irdy4; dout = dout4; ov = ov4; dp = dp4; dc = dc4;
    end else begin
      irdy = irdy3; dout = dout3; ov = {1'b0, ov3}; dp = dp3; dc = dc3;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_chan[i] = 0; m_data[i] = 0;
      m_rr[i] = 0; m_drops[i] = 0; m_pulse[i] = 0;
    end
  endtask

  function automatic int exp_ready(input int i);
    return (m_full[i] == 0 || ordy_v[i][m_chan[i]] == 1'b1) ? 1 : 0;
  endfunction

  // Apply one clock edge of the transaction rules to the model
  task automatic model_edge(input int i);
    int acc;
    int drained;
    int load;
    int tgt;
    acc     = (vld_v[i] == 1'b1 && exp_ready(i) == 1) ? 1 : 0;
    drained = (m_full[i] == 1 && ordy_v[i][m_chan[i]] == 1'b1) ? 1 : 0;
    load    = 0;
    tgt     = 0;
    m_pulse[i] = 0;
    if (acc == 1) begin
      if (mode_v[i] == 1'b1) begin
        tgt     = m_rr[i];
        m_rr[i] = (m_rr[i] + 1) % nch[i];
        load    = 1;
      end else if (int'(sel_v[i]) >= nch[i]) begin
        m_pulse[i] = 1;
        m_drops[i] = (m_drops[i] + 1 > 255) ? 255 : m_drops[i] + 1;
      end else begin
        tgt  = int'(sel_v[i]);
        load = 1;
      end
    end
    if (load == 1) begin
      m_full[i] = 1; m_chan[i] = tgt; m_data[i] = int'(din_v[i]);
    end else if (drained == 1) begin
      m_full[i] = 0;
    end
  endtask

  // One clock: check in_ready before the edge, then all registered outputs
  task automatic cycle();
    logic irdy; logic [7:0] dout; logic [3:0] ov; logic dp; logic [7:0] dc;
    #2;
    for (int i = 0; i < 2; i++) begin
      sample(i, irdy, dout, ov, dp, dc);
      chk($sformatf("u%0d.in_ready", i), 32'(irdy), 32'(exp_ready(i)));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      sample(i, irdy, dout, ov, dp, dc);
      chk($sformatf("u%0d.out_valid", i), 32'(ov), (m_full[i] == 1) ? (32'd1 << m_chan[i]) : 32'd0);
      if (m_full[i] == 1) chk($sformatf("u%0d.out_data", i), 32'(dout), 32'(m_data[i]));
      chk($sformatf("u%0d.drop_pulse", i), 32'(dp), 32'(m_pulse[i]));
      chk($sformatf("u%0d.drop_count", i), 32'(dc), 32'(m_drops[i]));
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      mode_v[i] = 1'b0; din_v[i] = 8'h00; sel_v[i] = 2'd0;
      vld_v[i] = 1'b0; ordy_v[i] = 4'hF;
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_ov3", 32'(ov3), 32'd0);
    chk("rst_irdy4", 32'(irdy4), 32'd1);
    chk("rst_irdy3", 32'(irdy3), 32'd1);
    chk("rst_dout4", 32'(dout4), 32'd0);
    chk("rst_dc3", 32'(dc3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Addressed routing on N=4: two beats to channels 2 then 0
    vld_v[0] = 1'b1; din_v[0] = 8'hA1; sel_v[0] = 2'd2;
    cycle();
    chk("s1_ov_a1", 32'(ov4), 32'b0100);
    chk("s1_data_a1", 32'(dout4), 32'hA1);
    din_v[0] = 8'hB2; sel_v[0] = 2'd0;
    cycle();
    chk("s1_ov_b2", 32'(ov4), 32'b0001);
    chk("s1_data_b2", 32'(dout4), 32'hB2);
    vld_v[0] = 1'b0;
    cycle();

    // Round-robin on N=3: six back-to-back beats
    mode_v[1] = 1'b1; vld_v[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      din_v[1] = 8'(k);
      cycle();
      chk("s2_rr_chan", 32'(ov3), 32'd1 << ((k - 1) % 3));
    end
    vld_v[1] = 1'b0;
    cycle();

    // Stall on channel 1 for five cycles while a second beat waits
    vld_v[0] = 1'b1; din_v[0] = 8'h55; sel_v[0] = 2'd1;
    cycle();
    din_v[0] = 8'h66; sel_v[0] = 2'd0; ordy_v[0] = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("s3_stall_ov", 32'(ov4), 32'b0010);
      chk("s3_stall_data", 32'(dout4), 32'h55);
    end
    ordy_v[0] = 4'hF;
    cycle();
    chk("s3_next_ov", 32'(ov4), 32'b0001);
    vld_v[0] = 1'b0;
    cycle();

    // Out-of-range select on N=3: every beat dropped, count saturates
    mode_v[1] = 1'b0; sel_v[1] = 2'd3; vld_v[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      din_v[1] = 8'($urandom);
      cycle();
      if (dp3 == 1'b1) pulses++;
    end
    vld_v[1] = 1'b0;
    cycle();
    chk("s4_pulses", 32'(pulses), 32'd300);
    chk("s4_drop_sat", 32'(dc3), 32'd255);

    // Reset asserted mid-cycle with a stalled beat held
    mode_v[0] = 1'b1; vld_v[0] = 1'b1; din_v[0] = 8'h70;
    cycle();
    mode_v[0] = 1'b0; din_v[0] = 8'h77; sel_v[0] = 2'd3; ordy_v[0] = 4'b0111;
    cycle();
    vld_v[0] = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s5_ov4", 32'(ov4), 32'd0);
    chk("s5_irdy4", 32'(irdy4), 32'd1);
    chk("s5_dc3", 32'(dc3), 32'd0);
    chk("s5_ov3", 32'(ov3), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_after_ov4", 32'(ov4), 32'd0);
    ordy_v[0] = 4'hF; mode_v[0] = 1'b1; vld_v[0] = 1'b1; din_v[0] = 8'h88;
    cycle();
    chk("s5_rr_restart", 32'(ov4), 32'b0001);

    // Mode toggles while a round-robin beat is held for channel 2
    din_v[0] = 8'h90;
    cycle();
    din_v[0] = 8'h91; ordy_v[0] = 4'b1011;
    cycle();
    vld_v[0] = 1'b0; mode_v[0] = 1'b0; sel_v[0] = 2'd0;
    repeat (2) begin
      cycle();
      chk("s6_held_ch2", 32'(ov4), 32'b0100);
    end
    ordy_v[0] = 4'hF;
    cycle();
    mode_v[0] = 1'b1; vld_v[0] = 1'b1; din_v[0] = 8'h92;
    cycle();
    chk("s6_rr_ch3", 32'(ov4), 32'b1000);
    vld_v[0] = 1'b0;
    cycle();

    // Randomised traffic on both instances
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        mode_v[i] = 1'($urandom);
        sel_v[i]  = 2'($urandom);
        din_v[i]  = 8'($urandom);
        vld_v[i]  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
        ordy_v[i] = 4'($urandom) | 4'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_1xn_stream.md
DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per beat.
REQ-002 SHALL have parameter N, default 4, output channel count; legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(N)).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  in  1  0 = addressed (route by sel), 1 = round-robin.
REQ-007 SHALL have port in_data  in  WIDTH  input beat payload.
REQ-008 SHALL have port in_sel  in  SEL_W  destination channel, used only when mode=0.
REQ-009 SHALL have port in_valid  in  1  input beat present.
REQ-010 SHALL have port in_ready  out  1  block accepts beat this cycle.
REQ-011 SHALL have port out_data  out  WIDTH  registered payload, shared by all channels.
REQ-012 SHALL have port out_valid  out  N  one-hot or zero; bit k = beat offered to channel k.
REQ-013 SHALL have port out_ready  in  N  per-channel consumer ready.
REQ-014 SHALL have port drop_pulse  out  1  one-cycle pulse when a beat is discarded.
REQ-015 SHALL have port drop_count  out  8  saturating count of discarded beats.

Function
REQ-016 SHALL hold one output register (payload + destination index + full flag); transfer on channel k when out_valid[k] && out_ready[k].
REQ-017 SHALL drive in_ready = !full || (out_ready[dest] when full); combinational, no dependence on in_valid.
REQ-018 SHALL accept a beat when in_valid && in_ready; beat appears on out_valid/out_data the next cycle (latency 1).
REQ-019 SHALL, on simultaneous drain and accept, load the new beat in the same edge with no bubble (full stays 1).
REQ-020 SHALL, in mode=0, set dest = in_sel at acceptance.
REQ-021 SHALL, in mode=0 with in_sel >= N, accept the beat, not load the register, pulse drop_pulse next cycle, increment drop_count.
REQ-022 SHALL saturate drop_count at 255; no wrap.
REQ-023 SHALL, in mode=1, set dest = rr_ptr at acceptance and advance rr_ptr by 1, wrapping N-1 -> 0; in_sel ignored.
REQ-024 SHALL leave rr_ptr unchanged in mode=0 and on cycles with no acceptance.
REQ-025 SHALL sample mode at acceptance only; a mode change never alters a beat already held.
REQ-026 SHALL keep out_data, dest stable while full && !out_ready[dest] (no payload change under stall).
REQ-027 SHALL drive out_valid to all-zero when not full; out_data value then don't-care but stable.
REQ-028 SHALL ignore out_ready bits of non-destination channels.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear full, rr_ptr=0, dest=0, out_data=0, drop_pulse=0, drop_count=0.
REQ-030 SHALL therefore drive out_valid=0 and in_ready=1 during and immediately after reset.
REQ-031 SHALL discard a held beat when reset asserts mid-operation; no beat delivered after release until new acceptance.

Structure
REQ-032 SHALL place the mode encoding constants (MODE_ADDR=0, MODE_RR=1) and a clog2-based SEL_W helper function in shared package demux_pkg.
REQ-033 SHALL implement the round-robin pointer as sub-module rr_ptr_gen (params N; ports clk, rst_n, advance, ptr).
REQ-034 SHALL contain no latches; all flops reset by rst_n.

Verification
REQ-035 SHALL cover: mode=0, N=4, beats 0xA1 sel=2, 0xB2 sel=0, all out_ready=1 -> out_valid 4'b0100 data 0xA1, then 4'b0001 data 0xB2, one cycle each, in_ready constantly 1.
REQ-036 SHALL cover: mode=1, N=3, six back-to-back beats 1..6, all ready -> channels 0,1,2,0,1,2 in order, no bubbles.
REQ-037 SHALL cover: mode=0, beat 0x55 sel=1, out_ready[1]=0 for 5 cycles, out_ready[0]=1 -> out_valid 4'b0010 held with 0x55 for 5 cycles, in_ready=0, second beat not accepted until drain.
REQ-038 SHALL cover: N=3, mode=0, in_sel=3 for 300 beats -> 300 drop_pulse cycles, out_valid always 0, drop_count ends 255.
REQ-039 SHALL cover: beat held and stalled, rst_n pulsed low mid-cycle -> out_valid=0 immediately, rr_ptr=0, drop_count=0, in_ready=1.
REQ-040 SHALL cover: mode toggled 1->0 while beat held for channel 2 -> delivered on channel 2; next mode=1 beat uses unchanged rr_ptr.
